// File: rtl/sq_pidb_wqe_fetch.sv
// sq_pidb_wqe_fetch: captures per-QP SQ producer-index doorbells and fetches pending 64-byte WQEs
// round-robin over single-beat AXI4 reads, presenting each on a valid/ready stream.
module sq_pidb_wqe_fetch #(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int NUM_QP = 8,
  parameter int SQ_DEPTH = 16,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] SQ_BASE_ADDR = 32'h8000_0000,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] QP_SQ_STRIDE = 32'h0000_1000
) (
  input  logic                        core_clk,
  input  logic                        core_aresetn,
  input  logic                        conf_of_reg_done,
  input  logic [15:0]                 i_qp_sq_pidb_hndshk,
  input  logic [31:0]                 i_qp_sq_pidb_wr_addr_hndshk,
  input  logic                        i_qp_sq_pidb_wr_valid_hndshk,
  output logic                        o_qp_sq_pidb_wr_rdy,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [511:0]                m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  output logic [511:0]                o_wqe_data,
  output logic [7:0]                  o_wqe_qpn,
  output logic                        o_wqe_valid,
  input  logic                        i_wqe_ready,
  output logic                        o_db_err,
  output logic                        o_rresp_err
);
  localparam int QW = NUM_QP > 1 ? $clog2(NUM_QP) : 1;
  localparam int CW = $clog2(SQ_DEPTH);
  typedef enum logic [2:0] {IDLE, AR, R, OUT, UPD} state_t;
  state_t state, state_n;
  logic [CW-1:0] pi [NUM_QP];
  logic [CW-1:0] ci [NUM_QP];
  logic [QW-1:0] rr_ptr, cur_qpn, sel, idx;
  logic [QW:0] sum;
  logic found, db_acc, db_legal, unused_ok;
  assign db_acc = i_qp_sq_pidb_wr_valid_hndshk & o_qp_sq_pidb_wr_rdy;
  assign db_legal = i_qp_sq_pidb_wr_addr_hndshk[31:16] == 16'h5004 &&
                    i_qp_sq_pidb_wr_addr_hndshk[7:0] == 8'h38 &&
                    {1'b0, i_qp_sq_pidb_wr_addr_hndshk[15:8]} < 9'(NUM_QP) &&
                    {1'b0, i_qp_sq_pidb_hndshk} < 17'(SQ_DEPTH);
  assign m_axi_arvalid = state == AR;
  assign m_axi_rready = state == R;
  assign o_wqe_valid = state == OUT;
  assign m_axi_arlen = 8'd0;
  assign m_axi_arsize = 3'b110;
  assign m_axi_arburst = 2'b01;
  assign unused_ok = m_axi_rlast;
  // Scan downward so the first pending QP at or after rr_ptr wins.
  always_comb begin
    sel = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int i = NUM_QP - 1; i >= 0; i--) begin
      sum = (QW+1)'(rr_ptr) + (QW+1)'(i);
      idx = QW'(sum >= (QW+1)'(NUM_QP) ? sum - (QW+1)'(NUM_QP) : sum);
      if (pi[idx] != ci[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = conf_of_reg_done && found ? AR : IDLE;
      AR:      state_n = m_axi_arready ? R : AR;
      R:       state_n = m_axi_rvalid ? OUT : R;
      OUT:     state_n = i_wqe_ready ? UPD : OUT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge core_clk) begin
    if (!core_aresetn) begin
      state <= IDLE;
      rr_ptr <= '0;
      cur_qpn <= '0;
      m_axi_araddr <= '0;
      o_wqe_data <= '0;
      o_wqe_qpn <= '0;
      o_db_err <= 1'b0;
      o_rresp_err <= 1'b0;
      o_qp_sq_pidb_wr_rdy <= 1'b1;
      for (int q = 0; q < NUM_QP; q++) begin
        pi[q] <= '0;
        ci[q] <= '0;
      end
    end else begin
      state <= state_n;
      o_qp_sq_pidb_wr_rdy <= !db_acc;
      o_db_err <= db_acc && !db_legal;
      if (db_acc && db_legal) pi[i_qp_sq_pidb_wr_addr_hndshk[QW+7:8]] <= i_qp_sq_pidb_hndshk[CW-1:0];
      if (state == IDLE && state_n == AR) begin
        cur_qpn <= sel;
        m_axi_araddr <= SQ_BASE_ADDR + C_AXI_ADDR_WIDTH'(sel) * QP_SQ_STRIDE + (C_AXI_ADDR_WIDTH'(ci[sel]) << 6);
      end
      if (state == R && m_axi_rvalid) begin
        o_wqe_data <= m_axi_rdata;
        o_wqe_qpn <= 8'(cur_qpn);
      end
      o_rresp_err <= state == R && m_axi_rvalid && m_axi_rresp != 2'b00;
      // SQ_DEPTH is a power of two, so the natural increment wraps SQ_DEPTH-1 to 0.
      if (state == UPD) begin
        ci[cur_qpn] <= ci[cur_qpn] + CW'(1);
        rr_ptr <= cur_qpn == QW'(NUM_QP - 1) ? '0 : cur_qpn + QW'(1);
      end
    end
  end
endmodule

// File: tb/tb_sq_pidb_wqe_fetch.sv
// tb_sq_pidb_wqe_fetch: directed and randomized scenarios checked against an array-based
// doorbell/consumer-index model with round-robin selection.
module tb_sq_pidb_wqe_fetch;
  logic core_clk = 0, core_aresetn = 0, conf_of_reg_done = 0;
  logic [15:0] i_qp_sq_pidb_hndshk = 0;
  logic [31:0] i_qp_sq_pidb_wr_addr_hndshk = 0;
  logic i_qp_sq_pidb_wr_valid_hndshk = 0, o_qp_sq_pidb_wr_rdy;
  logic [31:0] m_axi_araddr;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst;
  logic m_axi_arvalid, m_axi_arready = 0;
  logic [511:0] m_axi_rdata = 0;
  logic [1:0] m_axi_rresp = 0;
  logic m_axi_rlast = 0, m_axi_rvalid = 0, m_axi_rready;
  logic [511:0] o_wqe_data;
  logic [7:0] o_wqe_qpn;
  logic o_wqe_valid, i_wqe_ready = 0, o_db_err, o_rresp_err;
  int n_chk = 0, n_pass = 0;
  int m_pi [8];
  int m_ci [8];
  int m_rr;

  sq_pidb_wqe_fetch dut (
    .core_clk(core_clk), .core_aresetn(core_aresetn), .conf_of_reg_done(conf_of_reg_done),
    .i_qp_sq_pidb_hndshk(i_qp_sq_pidb_hndshk), .i_qp_sq_pidb_wr_addr_hndshk(i_qp_sq_pidb_wr_addr_hndshk),
    .i_qp_sq_pidb_wr_valid_hndshk(i_qp_sq_pidb_wr_valid_hndshk), .o_qp_sq_pidb_wr_rdy(o_qp_sq_pidb_wr_rdy),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .o_wqe_data(o_wqe_data),
    .o_wqe_qpn(o_wqe_qpn), .o_wqe_valid(o_wqe_valid), .i_wqe_ready(i_wqe_ready),
    .o_db_err(o_db_err), .o_rresp_err(o_rresp_err)
  );

  always #5 core_clk = ~core_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge core_clk);
    #1;
  endtask

  function automatic bit legal_db(input logic [31:0] a, input logic [15:0] p);
    return a[31:16] == 16'h5004 && a[7:0] == 8'h38 && a[15:8] < 8 && p < 16;
  endfunction

  function automatic int exp_next();
    for (int i = 0; i < 8; i++)
      if (m_pi[(m_rr + i) % 8] != m_ci[(m_rr + i) % 8]) return (m_rr + i) % 8;
    return -1;
  endfunction

  function automatic logic [31:0] exp_addr(input int q);
    return 32'h8000_0000 + q * 32'h1000 + m_ci[q] * 64;
  endfunction

  function automatic void model_done(input int q);
    m_ci[q] = (m_ci[q] + 1) % 16;
    m_rr = (q + 1) % 8;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic do_reset;
    core_aresetn = 0;
    conf_of_reg_done = 0;
    i_qp_sq_pidb_wr_valid_hndshk = 0;
    m_axi_arready = 0;
    m_axi_rvalid = 0;
    m_axi_rlast = 0;
    m_axi_rresp = 0;
    i_wqe_ready = 0;
    tick;
    tick;
    core_aresetn = 1;
    for (int q = 0; q < 8; q++) begin
      m_pi[q] = 0;
      m_ci[q] = 0;
    end
    m_rr = 0;
  endtask

  task automatic send_db(input logic [31:0] a, input logic [15:0] p, output bit acc, output logic err, output logic rdy_after);
    acc = 0;
    err = 'x;
    rdy_after = 'x;
    for (int n = 0; n < 8 && !o_qp_sq_pidb_wr_rdy; n++) tick;
    if (!o_qp_sq_pidb_wr_rdy) return;
    i_qp_sq_pidb_wr_addr_hndshk = a;
    i_qp_sq_pidb_hndshk = p;
    i_qp_sq_pidb_wr_valid_hndshk = 1;
    tick;
    i_qp_sq_pidb_wr_valid_hndshk = 0;
    acc = 1;
    err = o_db_err;
    rdy_after = o_qp_sq_pidb_wr_rdy;
    if (legal_db(a, p)) m_pi[a[15:8]] = int'(p);
  endtask

  task automatic idle_cycles(input int n, output bit seen);
    seen = 0;
    for (int k = 0; k < n; k++) begin
      tick;
      seen |= m_axi_arvalid;
    end
  endtask

  // Acts as the AXI slave and WQE consumer for one fetch; leaves the DUT back in IDLE.
  task automatic do_fetch(input int ar_wait, input int out_wait, input logic [1:0] resp, input logic [511:0] data,
                          output logic [31:0] a, output logic [7:0] qn, output logic [511:0] d,
                          output bit ok, output bit stable, output int rerr);
    ok = 0;
    stable = 1;
    rerr = 0;
    a = 'x;
    qn = 'x;
    d = 'x;
    for (int n = 0; n < 60 && !m_axi_arvalid; n++) tick;
    if (!m_axi_arvalid) return;
    a = m_axi_araddr;
    stable &= m_axi_arlen == 8'd0 && m_axi_arsize == 3'b110 && m_axi_arburst == 2'b01;
    for (int n = 0; n < ar_wait; n++) begin
      tick;
      stable &= m_axi_arvalid && m_axi_araddr == a;
    end
    m_axi_arready = 1;
    tick;
    m_axi_arready = 0;
    if (m_axi_arvalid || !m_axi_rready) return;
    m_axi_rvalid = 1;
    m_axi_rdata = data;
    m_axi_rresp = resp;
    m_axi_rlast = 1;
    tick;
    m_axi_rvalid = 0;
    m_axi_rlast = 0;
    m_axi_rresp = 0;
    rerr += int'(o_rresp_err);
    if (!o_wqe_valid || m_axi_rready) return;
    d = o_wqe_data;
    qn = o_wqe_qpn;
    for (int n = 0; n < out_wait; n++) begin
      tick;
      stable &= o_wqe_valid && o_wqe_data == d && o_wqe_qpn == qn && !m_axi_arvalid;
      rerr += int'(o_rresp_err);
    end
    i_wqe_ready = 1;
    tick;
    i_wqe_ready = 0;
    rerr += int'(o_rresp_err);
    if (o_wqe_valid) return;
    tick;
    ok = 1;
  endtask

  // Fetches everything the model says is pending, in model order, then expects silence.
  task automatic run_drain(input string tag);
    int q;
    logic [31:0] a;
    logic [7:0] qn;
    logic [511:0] d, data;
    bit ok, st, seen;
    int re;
    for (int k = 0; k < 200; k++) begin
      q = exp_next();
      if (q < 0) break;
      data = rand512();
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), 2'b00, data, a, qn, d, ok, st, re);
      n_chk++;
      if (!ok || !st || re != 0) $display("FAIL %s handshake k=%0d: ok=%0d stable=%0d rerr=%0d, want 1 1 0", tag, k, ok, st, re);
      else n_pass++;
      n_chk++;
      if (a !== exp_addr(q)) $display("FAIL %s araddr k=%0d: got %h want %h", tag, k, a, exp_addr(q));
      else n_pass++;
      n_chk++;
      if (qn !== 8'(q) || d !== data) $display("FAIL %s wqe k=%0d: qpn %0d want %0d, data_match=%0d", tag, k, qn, q, d === data);
      else n_pass++;
      model_done(q);
    end
    idle_cycles(12, seen);
    n_chk++;
    if (seen) $display("FAIL %s idle_after_drain: arvalid seen, want none", tag);
    else n_pass++;
  endtask

  task automatic test_reset;
    core_aresetn = 0;
    tick;
    n_chk++;
    if ({o_qp_sq_pidb_wr_rdy, m_axi_arvalid, m_axi_rready, o_wqe_valid, o_db_err, o_rresp_err} !== 6'b100000)
      $display("FAIL reset_ctrl: got %b want 100000", {o_qp_sq_pidb_wr_rdy, m_axi_arvalid, m_axi_rready, o_wqe_valid, o_db_err, o_rresp_err});
    else n_pass++;
    n_chk++;
    if (m_axi_araddr !== 32'h0 || o_wqe_data !== 512'h0 || o_wqe_qpn !== 8'h0)
      $display("FAIL reset_data: araddr %h qpn %h, want 0 0 and zero data", m_axi_araddr, o_wqe_qpn);
    else n_pass++;
    n_chk++;
    if ({m_axi_arlen, m_axi_arsize, m_axi_arburst} !== {8'd0, 3'b110, 2'b01})
      $display("FAIL reset_consts: arlen %h arsize %b arburst %b", m_axi_arlen, m_axi_arsize, m_axi_arburst);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_basic;
    bit acc, ok, st, seen;
    logic err, rdy;
    logic [31:0] a;
    logic [7:0] qn;
    logic [511:0] d, data;
    int re;
    do_reset();
    conf_of_reg_done = 1;
    send_db(32'h5004_0338, 16'd3, acc, err, rdy);
    n_chk++;
    if (!acc || err !== 1'b0 || rdy !== 1'b0) $display("FAIL basic_db: acc=%0d err=%b rdy=%b, want 1 0 0", acc, err, rdy);
    else n_pass++;
    for (int e = 0; e < 3; e++) begin
      data = rand512();
      do_fetch(0, 0, 2'b00, data, a, qn, d, ok, st, re);
      n_chk++;
      if (!ok || a !== 32'h8000_3000 + 32'(e * 64) || qn !== 8'd3 || d !== data)
        $display("FAIL basic_fetch e=%0d: ok=%0d addr %h qpn %0d, want 1 %h 3", e, ok, a, qn, 32'h8000_3000 + 32'(e * 64));
      else n_pass++;
      model_done(3);
    end
    idle_cycles(12, seen);
    n_chk++;
    if (seen) $display("FAIL basic_idle: arvalid after ci caught up, want none");
    else n_pass++;
  endtask

  task automatic test_round_robin;
    bit acc, ok, st, seen;
    logic err, rdy;
    logic [31:0] a;
    logic [7:0] qn;
    logic [511:0] d;
    int re;
    logic [31:0] exp_a [3] = '{32'h8000_1000, 32'h8000_4000, 32'h8000_1040};
    logic [7:0] exp_q [3] = '{8'd1, 8'd4, 8'd1};
    do_reset();
    send_db(32'h5004_0138, 16'd2, acc, err, rdy);
    send_db(32'h5004_0438, 16'd1, acc, err, rdy);
    idle_cycles(8, seen);
    n_chk++;
    if (seen) $display("FAIL rr_gated: arvalid while conf_of_reg_done=0, want none");
    else n_pass++;
    conf_of_reg_done = 1;
    for (int k = 0; k < 3; k++) begin
      do_fetch(0, 0, 2'b00, rand512(), a, qn, d, ok, st, re);
      n_chk++;
      if (!ok || a !== exp_a[k] || qn !== exp_q[k]) $display("FAIL rr_order k=%0d: addr %h qpn %0d, want %h %0d", k, a, qn, exp_a[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_illegal;
    bit acc, seen;
    logic err, rdy;
    logic [31:0] bad_a [3] = '{32'h5004_0F38, 32'h5004_0334, 32'h5004_0338};
    logic [15:0] bad_p [3] = '{16'd1, 16'd1, 16'd16};
    do_reset();
    conf_of_reg_done = 1;
    for (int k = 0; k < 3; k++) begin
      send_db(bad_a[k], bad_p[k], acc, err, rdy);
      n_chk++;
      if (!acc || err !== 1'b1) $display("FAIL illegal_err k=%0d: acc=%0d db_err=%b, want 1 1", k, acc, err);
      else n_pass++;
      tick;
      n_chk++;
      if (o_db_err !== 1'b0) $display("FAIL illegal_pulse k=%0d: db_err=%b one cycle later, want 0", k, o_db_err);
      else n_pass++;
    end
    idle_cycles(12, seen);
    n_chk++;
    if (seen) $display("FAIL illegal_axi: arvalid after dropped doorbells, want none");
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    bit acc;
    logic err, rdy;
    logic [3:0] r;
    do_reset();
    i_qp_sq_pidb_wr_addr_hndshk = 32'h5004_0238;
    i_qp_sq_pidb_hndshk = 16'd5;
    i_qp_sq_pidb_wr_valid_hndshk = 1;
    for (int k = 0; k < 4; k++) begin
      r[k] = o_qp_sq_pidb_wr_rdy;
      tick;
    end
    i_qp_sq_pidb_wr_valid_hndshk = 0;
    m_pi[2] = 5;
    n_chk++;
    if (r !== 4'b0101) $display("FAIL b2b_rdy: rdy samples (k3..k0) %b, want 0101", r);
    else n_pass++;
    send_db(32'h5004_0238, 16'd1, acc, err, rdy);
    conf_of_reg_done = 1;
    run_drain("overwrite");
  endtask

  task automatic test_ar_stall;
    bit acc, ok, st;
    logic err, rdy;
    logic [31:0] a;
    logic [7:0] qn;
    logic [511:0] d, data;
    int re;
    do_reset();
    conf_of_reg_done = 1;
    send_db(32'h5004_0538, 16'd1, acc, err, rdy);
    data = rand512();
    do_fetch(10, 0, 2'b10, data, a, qn, d, ok, st, re);
    n_chk++;
    if (!ok || !st || a !== 32'h8000_5000) $display("FAIL ar_stall: ok=%0d stable=%0d addr %h, want 1 1 80005000", ok, st, a);
    else n_pass++;
    n_chk++;
    if (re != 1) $display("FAIL rresp_err: pulses %0d, want 1", re);
    else n_pass++;
    n_chk++;
    if (qn !== 8'd5 || d !== data) $display("FAIL rresp_deliver: qpn %0d data_match=%0d, want 5 1", qn, d === data);
    else n_pass++;
  endtask

  task automatic test_out_stall;
    bit acc, ok, st;
    logic err, rdy;
    logic [31:0] a;
    logic [7:0] qn;
    logic [511:0] d, data;
    int re;
    do_reset();
    conf_of_reg_done = 1;
    send_db(32'h5004_0638, 16'd2, acc, err, rdy);
    data = rand512();
    do_fetch(0, 20, 2'b00, data, a, qn, d, ok, st, re);
    n_chk++;
    if (!ok || !st || d !== data || qn !== 8'd6) $display("FAIL out_stall: ok=%0d stable=%0d qpn %0d, want 1 1 6", ok, st, qn);
    else n_pass++;
    do_fetch(0, 0, 2'b00, rand512(), a, qn, d, ok, st, re);
    n_chk++;
    if (!ok || a !== 32'h8000_6040) $display("FAIL out_stall_next: ok=%0d addr %h, want 1 80006040", ok, a);
    else n_pass++;
  endtask

  task automatic test_wrap_reset;
    bit acc, ok, st, seen;
    logic err, rdy;
    logic [31:0] a;
    logic [7:0] qn;
    logic [511:0] d;
    int re;
    logic [31:0] exp_a [4] = '{32'h8000_0380, 32'h8000_03C0, 32'h8000_0000, 32'h8000_0040};
    do_reset();
    conf_of_reg_done = 1;
    send_db(32'h5004_0038, 16'd14, acc, err, rdy);
    run_drain("advance");
    send_db(32'h5004_0038, 16'd2, acc, err, rdy);
    for (int k = 0; k < 4; k++) begin
      do_fetch(0, 0, 2'b00, rand512(), a, qn, d, ok, st, re);
      n_chk++;
      if (!ok || a !== exp_a[k] || qn !== 8'd0) $display("FAIL wrap k=%0d: addr %h qpn %0d, want %h 0", k, a, qn, exp_a[k]);
      else n_pass++;
    end
    idle_cycles(12, seen);
    n_chk++;
    if (seen) $display("FAIL wrap_idle: arvalid with ci=pi=2, want none");
    else n_pass++;
    send_db(32'h5004_0038, 16'd3, acc, err, rdy);
    for (int n = 0; n < 20 && !m_axi_arvalid; n++) tick;
    n_chk++;
    if (m_axi_arvalid !== 1'b1) $display("FAIL reset_ar_setup: arvalid %b, want 1", m_axi_arvalid);
    else n_pass++;
    core_aresetn = 0;
    tick;
    core_aresetn = 1;
    for (int q = 0; q < 8; q++) begin
      m_pi[q] = 0;
      m_ci[q] = 0;
    end
    m_rr = 0;
    n_chk++;
    if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 || m_axi_araddr !== 32'h0)
      $display("FAIL reset_mid_ar: arvalid %b rready %b araddr %h, want 0 0 0", m_axi_arvalid, m_axi_rready, m_axi_araddr);
    else n_pass++;
    idle_cycles(12, seen);
    n_chk++;
    if (seen) $display("FAIL reset_cleared: arvalid after reset with conf high, want none");
    else n_pass++;
    send_db(32'h5004_0038, 16'd1, acc, err, rdy);
    do_fetch(0, 0, 2'b00, rand512(), a, qn, d, ok, st, re);
    n_chk++;
    if (!ok || a !== 32'h8000_0000) $display("FAIL reset_ci: addr %h, want 80000000", a);
    else n_pass++;
  endtask

  task automatic test_random;
    bit acc;
    logic err, rdy;
    logic [31:0] a;
    logic [15:0] p;
    do_reset();
    for (int r = 0; r < 6; r++) begin
      conf_of_reg_done = 0;
      for (int k = 0; k < 5; k++) begin
        a = {($urandom_range(0, 7) == 0) ? 16'h5005 : 16'h5004, 8'($urandom_range(0, 9)),
             ($urandom_range(0, 5) == 0) ? 8'h34 : 8'h38};
        p = 16'($urandom_range(0, 17));
        send_db(a, p, acc, err, rdy);
        n_chk++;
        if (!acc || err !== !legal_db(a, p)) $display("FAIL rand_db r=%0d k=%0d: addr %h pi %0d err=%b, want %b", r, k, a, p, err, !legal_db(a, p));
        else n_pass++;
      end
      conf_of_reg_done = 1;
      run_drain("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_illegal();
    test_back_to_back();
    test_ar_stall();
    test_out_stall();
    test_wrap_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
